// File: rtl/sr_drive_pkg.sv
// sr_drive_pkg: shared op encodings, FSM states and counter width for sr_drive_ctrl
package sr_drive_pkg;

    localparam int CNT_W = 8;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_RST  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

    typedef enum logic [1:0] {IDLE, PULSE, GAP, CHECK} state_t;

endpackage

// File: rtl/sr_drive_timer.sv
// sr_drive_timer: loadable down-counter that stops at zero and flags it
module sr_drive_timer
    import sr_drive_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // load takes priority; otherwise count down and park at zero
    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;

    assign zero = cnt == '0;

endmodule

// File: rtl/sr_drive_ctrl.sv
// sr_drive_ctrl: pulse-width controlled s/r driver for an SR flip-flop; SR_DRIVE_VERIFY_EN adds a q feedback check
module sr_drive_ctrl
    import sr_drive_pkg::*;
#(
    parameter int PULSE_W = 1,
    parameter int GAP_W   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_op,
    output logic       req_ready,
    input  logic       q_fb,
    output logic       s,
    output logic       r,
    output logic       busy,
    output logic       done,
    output logic       err
);

    state_t           state, state_n;
    logic             s_n, r_n, done_n, err_n;
    logic             exp_q, exp_n, is_hold, hold_n;
    logic             load, zero, tgt;
    logic [CNT_W-1:0] load_val;

    sr_drive_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .zero     (zero)
    );

    // target level of q: set forces 1, toggle inverts the level seen at acceptance
    assign tgt  = (req_op == OP_SET) || (req_op == OP_TGL && !q_fb);
    assign busy = state != IDLE;

    // next-state, next-output and timer control
    always_comb begin
        state_n  = state;
        s_n      = s;
        r_n      = r;
        exp_n    = exp_q;
        hold_n   = is_hold;
        done_n   = 1'b0;
        err_n    = 1'b0;
        load     = 1'b0;
        load_val = CNT_W'(PULSE_W - 1);
        case (state)
            IDLE:
                if (req_valid && req_ready) begin
                    load   = 1'b1;
                    hold_n = req_op == OP_HOLD;
                    if (req_op == OP_HOLD) begin
                        state_n  = GAP;
                        load_val = CNT_W'(GAP_W - 1);
                    end else begin
                        state_n = PULSE;
                        s_n     = tgt;
                        r_n     = !tgt;
                        exp_n   = tgt;
                    end
                end
            PULSE:
                if (zero) begin
                    state_n  = GAP;
                    s_n      = 1'b0;
                    r_n      = 1'b0;
                    load     = 1'b1;
                    load_val = CNT_W'(GAP_W - 1);
                end
            GAP:
                if (zero) begin
`ifdef SR_DRIVE_VERIFY_EN
                    state_n = is_hold ? IDLE : CHECK;
                    done_n  = is_hold;
`else
                    state_n = IDLE;
                    done_n  = 1'b1;
`endif
                end
`ifdef SR_DRIVE_VERIFY_EN
            CHECK: begin
                state_n = IDLE;
                done_n  = 1'b1;
                err_n   = q_fb != exp_q;
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    // state and registered outputs; reset drops s/r immediately
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= IDLE;
            s         <= 1'b0;
            r         <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            req_ready <= 1'b0;
            exp_q     <= 1'b0;
            is_hold   <= 1'b0;
        end else begin
            state     <= state_n;
            s         <= s_n;
            r         <= r_n;
            done      <= done_n;
            err       <= err_n;
            req_ready <= state_n == IDLE;
            exp_q     <= exp_n;
            is_hold   <= hold_n;
        end

    // the forbidden s=r=1 drive must never appear
    a_no_sr: assert property (@(posedge clk) !(s && r));

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// tb_sr_drive_ctrl: table-driven scoreboard bench for sr_drive_ctrl driving a modelled SR flip-flop
module tb_sr_drive_ctrl;
    import sr_drive_pkg::*;

    localparam int PW = 2;
    localparam int GW = 1;
`ifdef SR_DRIVE_VERIFY_EN
    localparam int VER = 1;
`else
    localparam int VER = 0;
`endif

    logic       clk = 1'b0, rst = 1'b1, req_valid = 1'b0, force_lo = 1'b0, q;
    logic [1:0] req_op = OP_HOLD;
    logic       req_ready, q_fb, s, r, busy, done, err;

    typedef struct {logic [1:0] op; int s_cnt; int r_cnt; logic q;} vec_t;
    typedef struct {int s_cnt; int r_cnt; logic q; logic err; int lat;} exp_t;

    vec_t tbl[8];
    exp_t sb[$];
    int   vectors = 0, fails = 0;

    always #5 clk = ~clk;

    // SR flip-flop driven by the DUT
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= 1'b0;
        else if (s) q <= 1'b1;
        else if (r) q <= 1'b0;

    assign q_fb = force_lo ? 1'b0 : q;

    sr_drive_ctrl #(.PULSE_W(PW), .GAP_W(GW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_ready(req_ready),
        .q_fb(q_fb), .s(s), .r(r), .busy(busy), .done(done), .err(err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("ready_wait", req_ready, 1);
    endtask

    task automatic run_cmd(input vec_t v, input logic exp_err);
        exp_t e, g;
        int   k = 0;
        logic ov = 1'b0;
        wait_ready();
        req_valid = 1'b1;
        req_op    = v.op;
        sb.push_back('{v.s_cnt, v.r_cnt, v.q, exp_err, (v.op == OP_HOLD) ? GW : PW + GW + VER});
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        g = '{0, 0, 1'b0, 1'b0, 0};
        while (!done && k < 60) begin
            g.s_cnt += int'(s);
            g.r_cnt += int'(r);
            ov |= s & r;
            @(negedge clk);
            k++;
        end
        chk("done_seen", done, 1);
        g.q   = q;
        g.err = err;
        g.lat = k;
        e = sb.pop_front();
        chk("s_cycles", g.s_cnt, e.s_cnt);
        chk("r_cycles", g.r_cnt, e.r_cnt);
        chk("q_after", g.q, e.q);
        chk("err_at_done", g.err, e.err);
        chk("latency", g.lat, e.lat);
        chk("s_and_r", ov, 0);
        @(negedge clk);
        chk("done_pulse_end", done, 0);
        chk("err_pulse_end", err, 0);
    endtask

    initial begin
        int   acc[2];
        int   n;
        logic ov, eseen;
        tbl[0] = '{OP_SET,  PW, 0,  1'b1};
        tbl[1] = '{OP_TGL,  0,  PW, 1'b0};
        tbl[2] = '{OP_TGL,  PW, 0,  1'b1};
        tbl[3] = '{OP_RST,  0,  PW, 1'b0};
        tbl[4] = '{OP_HOLD, 0,  0,  1'b0};
        tbl[5] = '{OP_RST,  0,  PW, 1'b0};
        tbl[6] = '{OP_SET,  PW, 0,  1'b1};
        tbl[7] = '{OP_HOLD, 0,  0,  1'b1};

        // reset held for two cycles
        @(negedge clk);
        @(negedge clk);
        chk("rst_s", s, 0);
        chk("rst_r", r, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", req_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", req_ready, 1);

        foreach (tbl[i]) run_cmd(tbl[i], 1'b0);

        // feedback held low while setting
        force_lo = 1'b1;
        run_cmd('{OP_SET, PW, 0, 1'b1}, VER == 1);
        force_lo = 1'b0;

        // reset asserted mid-pulse
        wait_ready();
        req_valid = 1'b1;
        req_op    = OP_SET;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("mid_s_high", s, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_s_async", s, 0);
        chk("mid_r_async", r, 0);
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_ready", req_ready, 1);
        chk("mid_no_done", done, 0);

        // back-to-back: reset then set with valid held
        req_valid = 1'b1;
        req_op    = OP_RST;
        n = 0;
        ov = 1'b0;
        eseen = 1'b0;
        for (int t = 0; t < 60 && n < 2; t++) begin
            @(negedge clk);
            ov |= s & r;
            eseen |= err;
            if (n == 1) req_op = OP_SET;
            if (req_ready) begin
                acc[n] = t;
                n++;
            end
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("b2b_accepts", n, 2);
        chk("b2b_spacing", acc[1] - acc[0], PW + GW + VER + 1);
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            ov |= s & r;
            eseen |= err;
            n++;
        end
        chk("b2b_done", done, 1);
        chk("b2b_q", q, 1);
        chk("b2b_s_and_r", ov, 0);
        chk("b2b_err", eseen | err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
